param_shift_serdes: RTL and testbench



---
 rtl/param_shift_serdes.sv | 113 +++++++++++
 tb/tb_param_shift_serdes.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/param_shift_serdes.sv
// param_shift_serdes: WIDTH-bit universal register with parallel load and a
// bounded WIDTH-step serial shift in either direction, plus Busy/Done status.
// Optional build macro: SERDES_NEGEDGE_OUT_EN (SerOut re-timed on falling Clk).
module param_shift_serdes #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Load,
    input  logic [WIDTH-1:0] D,
    input  logic             Start,
    input  logic             Dir,
    input  logic             SerIn,
    output logic             SerOut,
    output logic [WIDTH-1:0] Q,
    output logic             Busy,
    output logic             Done
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               dir_q, dir_d;
    logic               ser_out_c;

    // State and datapath registers, synchronous active-high reset
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            q_q     <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
        end
    end

    // Next-state and datapath update; Load/Start only honoured in IDLE
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        case (state_q)
            ST_IDLE: begin
                if (Load) begin
                    q_d = D;
                end
                if (Start) begin
                    dir_d   = Dir;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (dir_q) begin
                    q_d = {q_q[WIDTH-2:0], SerIn};
                end else begin
                    q_d = {SerIn, q_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + CNT_W'(1);
                // Last shift of the sequence leaves the counter at WIDTH
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Bit that leaves on the next shift, chosen by the latched direction
    always_comb begin
        ser_out_c = dir_q ? q_q[WIDTH-1] : q_q[0];
    end

`ifdef SERDES_NEGEDGE_OUT_EN
    logic ser_out_q;

    // Half-cycle re-timing so a rising-edge receiver sees a centred bit
    always_ff @(negedge Clk) begin
        if (Reset) begin
            ser_out_q <= 1'b0;
        end else begin
            ser_out_q <= ser_out_c;
        end
    end

    assign SerOut = ser_out_q;
`else
    assign SerOut = ser_out_c;
`endif

    assign Q    = q_q;
    assign Busy = (state_q == ST_SHIFT);
    assign Done = (state_q == ST_DONE);

endmodule

// File: tb/tb_param_shift_serdes.sv
// Randomised self-checking bench for param_shift_serdes (WIDTH=8).
// The reference computes Q in closed form from the value at sequence start
// and the serial bits received so far.
module tb_param_shift_serdes;

    localparam int unsigned W = 8;

    logic         Clk;
    logic         Reset;
    logic         Load;
    logic [W-1:0] D;
    logic         Start;
    logic         Dir;
    logic         SerIn;
    logic         SerOut;
    logic [W-1:0] Q;
    logic         Busy;
    logic         Done;

    int n_vec;
    int n_err;

    // Reference model: 0 idle, 1 shifting, 2 done
    int           m_state;
    logic [W-1:0] m_q;
    logic [W-1:0] m_base;
    logic [W-1:0] m_sin;
    logic         m_dir;
    int           m_n;
    logic         m_so_prev;
    bit           m_first;

    param_shift_serdes #(.WIDTH(W)) dut (
        .Clk    (Clk),
        .Reset  (Reset),
        .Load   (Load),
        .D      (D),
        .Start  (Start),
        .Dir    (Dir),
        .SerIn  (SerIn),
        .SerOut (SerOut),
        .Q      (Q),
        .Busy   (Busy),
        .Done   (Done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Register contents after n shifts from base, sin[i] = i-th serial bit
    function automatic logic [W-1:0] exp_q(input logic [W-1:0] base, input logic d,
                                           input int n, input logic [W-1:0] sin);
        logic [W-1:0] r;
        if (!d) begin
            r = base >> n;
            for (int i = 0; i < n; i++) r[W-n+i] = sin[i];
        end else begin
            r = base << n;
            for (int i = 0; i < n; i++) r[n-1-i] = sin[i];
        end
        return r;
    endfunction

    // Apply one cycle of inputs, advance the model, check all outputs
    task automatic cycle(input logic rst, input logic ld, input logic [W-1:0] d,
                         input logic st, input logic dr, input logic si);
        logic exp_so;
        Reset = rst; Load = ld; D = d; Start = st; Dir = dr; SerIn = si;
        @(posedge Clk);
        if (rst) begin
            m_state = 0; m_q = '0; m_dir = 1'b0;
        end else begin
            case (m_state)
                0: begin
                    if (ld) m_q = d;
                    if (st) begin
                        m_base = m_q; m_dir = dr; m_n = 0; m_sin = '0; m_state = 1;
                    end
                end
                1: begin
                    m_sin[m_n] = si;
                    m_n++;
                    m_q = exp_q(m_base, m_dir, m_n, m_sin);
                    if (m_n == W) m_state = 2;
                end
                default: m_state = 0;
            endcase
        end
`ifdef SERDES_NEGEDGE_OUT_EN
        #1;
        if (!m_first) check_val("serout_hold_at_rise", 32'(SerOut), 32'(m_so_prev));
`endif
        @(negedge Clk);
        #1;
        exp_so = m_dir ? m_q[W-1] : m_q[0];
        check_val("q", 32'(Q), 32'(m_q));
        check_val("busy", 32'(Busy), 32'(m_state == 1));
        check_val("done", 32'(Done), 32'(m_state == 2));
        check_val("serout", 32'(SerOut), 32'(exp_so));
        m_so_prev = exp_so;
        m_first   = 1'b0;
    endtask

    int           busy_cnt;
    int           done_cnt;
    logic [W-1:0] so_bits;
    logic [W-1:0] pat;

    initial begin
        n_vec = 0; n_err = 0;
        m_state = 0; m_q = '0; m_base = '0; m_sin = '0; m_dir = 1'b0; m_n = 0;
        m_so_prev = 1'b0; m_first = 1'b1;

        // Reset with Load asserted must still clear
        cycle(1, 1, 8'hFF, 0, 0, 0);
        cycle(1, 1, 8'hFF, 0, 0, 0);
        cycle(0, 0, 8'h00, 0, 0, 0);
        check_val("reset_q", 32'(Q), 32'h0);

        // Plain load
        cycle(0, 1, 8'hA5, 0, 0, 0);
        check_val("load_q", 32'(Q), 32'hA5);

        // Right shift of A5 with SerIn=0; collect the serial stream
        busy_cnt = 0; done_cnt = 0; so_bits = '0;
        cycle(0, 0, 8'h00, 1, 0, 0);
        for (int i = 0; i < 11; i++) begin
            if (Busy) begin
                if (busy_cnt < int'(W)) so_bits[busy_cnt] = SerOut;
                busy_cnt++;
            end
            if (Done) done_cnt++;
            cycle(0, 0, 8'h00, 0, 0, 0);
        end
        check_val("r_serout_stream", 32'(so_bits), 32'hA5);
        check_val("r_busy_cycles", 32'(busy_cnt), 32'd8);
        check_val("r_done_cycles", 32'(done_cnt), 32'd1);
        check_val("r_final_q", 32'(Q), 32'h00);

        // Load-and-go left shift of 81, with Load/Start pulsed while busy/done
        pat = 8'b0101_0011; // bit i = i-th serial bit: 1,1,0,0,1,0,1,0
        busy_cnt = 0; done_cnt = 0;
        cycle(0, 1, 8'h81, 1, 1, 0);
        check_val("l_first_serout", 32'(SerOut), 32'h1);
        for (int i = 0; i < int'(W) + 1; i++) begin
            if (Busy) busy_cnt++;
            if (Done) done_cnt++;
            cycle(0, (i % 2) == 0, 8'hFF, 1'b1, 1'b0, (i < int'(W)) ? pat[i] : 1'b0);
        end
        if (Done) done_cnt++;
        check_val("l_final_q", 32'(Q), 32'hCA);
        check_val("l_busy_cycles", 32'(busy_cnt), 32'd8);
        check_val("l_done_cycles", 32'(done_cnt), 32'd1);
        cycle(0, 0, 8'h00, 0, 0, 0);

        // Abort after three shifts, then a full run
        cycle(0, 1, 8'h3C, 1, 0, 1);
        for (int i = 0; i < 3; i++) cycle(0, 0, 8'h00, 0, 0, 1);
        cycle(1, 0, 8'h00, 0, 0, 1);
        check_val("abort_busy", 32'(Busy), 32'h0);
        done_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 8'h00, 0, 0, 0);
            if (Done) done_cnt++;
        end
        check_val("abort_no_done", 32'(done_cnt), 32'd0);
        busy_cnt = 0;
        cycle(0, 0, 8'h00, 1, 1, 1);
        for (int i = 0; i < 10; i++) begin
            if (Busy) busy_cnt++;
            cycle(0, 0, 8'h00, 0, 0, 1);
        end
        check_val("post_abort_busy_cycles", 32'(busy_cnt), 32'd8);
        check_val("post_abort_q", 32'(Q), 32'hFF);

        // Randomised traffic against the model
        for (int i = 0; i < 1500; i++) begin
            cycle(($urandom % 80) == 0, ($urandom % 4) == 0, W'($urandom),
                  ($urandom % 5) == 0, 1'($urandom), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
